// File: rtl/debounce_sync_if.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_sync_if
//  Description : Signal bundle between a raw level source and the
//                debounce_sync conditioner. The master drives the raw level
//                and observes the conditioned outputs; the slave is the
//                conditioner itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface debounce_sync_if #(
   parameter int GLITCH_W = 8
);
   logic                d;
   logic                q;
   logic                rise;
   logic                fall;
   logic [GLITCH_W-1:0] glitch_cnt;

   modport master (
      output d,
      input  q,
      input  rise,
      input  fall,
      input  glitch_cnt
   );

   modport slave (
      input  d,
      output q,
      output rise,
      output fall,
      output glitch_cnt
   );
endinterface : debounce_sync_if
`default_nettype wire

// File: rtl/debounce_sync.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_sync
//  Description : Debounces a noisy 1-bit level into a clean registered level
//                q, with single-cycle rise/fall pulses and a saturating count
//                of aborted transitions. The level must hold for
//                STABLE_CYCLES consecutive sampled edges before q follows it.
//                Optional macro DEBOUNCE_SYNC_EN inserts a 2-flop
//                synchronizer in front of the filter (adds 2 cycles latency)
//                so d may be fully asynchronous.
//                The GLITCH_W parameter must match the interface GLITCH_W.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_sync #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8,
   parameter int GLITCH_W      = 8
) (
   input  wire              clk,
   input  wire              reset,
   debounce_sync_if.slave   bus
);

   // ------------------------------------------------------------------------
   // Parameter legality
   // ------------------------------------------------------------------------
   generate
      if (STABLE_CYCLES < 2) begin : g_bad_stable_cycles
         $error("debounce_sync: STABLE_CYCLES must be >= 2");
      end
      if (CNT_W < 1 || CNT_W > 30 ||
          (STABLE_CYCLES - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
         $error("debounce_sync: CNT_W too narrow to hold STABLE_CYCLES-1");
      end
   endgenerate

   localparam logic [CNT_W-1:0]    c_cnt_last  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]    c_cnt_one   = CNT_W'(1);
   localparam logic [GLITCH_W-1:0] c_glitch_max = '1;

   typedef enum logic [1:0] {
      STABLE0 = 2'd0,
      PEND1   = 2'd1,
      STABLE1 = 2'd2,
      PEND0   = 2'd3
   } state_t;

   // ------------------------------------------------------------------------
   // Sampled input
   // ------------------------------------------------------------------------
   logic w_s;

`ifdef DEBOUNCE_SYNC_EN
   logic [1:0] r_sync;

   // Two-stage synchronizer bringing an asynchronous d into the clk domain
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync <= 2'b00;
      end else begin
         r_sync <= {r_sync[0], bus.d};
      end
   end

   assign w_s = r_sync[1];
`else
   assign w_s = bus.d;
`endif

   // ------------------------------------------------------------------------
   // Filter state
   // ------------------------------------------------------------------------
   state_t              r_state;
   state_t              w_state_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic                r_q;
   logic                w_q_nxt;
   logic                r_rise;
   logic                w_rise_nxt;
   logic                r_fall;
   logic                w_fall_nxt;
   logic [GLITCH_W-1:0] r_glitch;
   logic [GLITCH_W-1:0] w_glitch_nxt;
   logic [GLITCH_W-1:0] w_glitch_inc;

   // Glitch counter increment that sticks at all-ones instead of wrapping
   assign w_glitch_inc = (r_glitch == c_glitch_max) ? r_glitch
                                                    : r_glitch + 1'b1;

   // State register; reset discards any pending transition
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= STABLE0;
         r_cnt    <= '0;
         r_q      <= 1'b0;
         r_rise   <= 1'b0;
         r_fall   <= 1'b0;
         r_glitch <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_q      <= w_q_nxt;
         r_rise   <= w_rise_nxt;
         r_fall   <= w_fall_nxt;
         r_glitch <= w_glitch_nxt;
      end
   end

   // Next-state logic: count consecutive samples at the new level, commit
   // on the last one, or abort and log a glitch if the level reverts early
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_q_nxt      = r_q;
      w_rise_nxt   = 1'b0;
      w_fall_nxt   = 1'b0;
      w_glitch_nxt = r_glitch;

      case (r_state)
         STABLE0: begin
            if (w_s) begin
               w_state_nxt = PEND1;
               w_cnt_nxt   = c_cnt_one;
            end
         end
         PEND1: begin
            if (!w_s) begin
               w_state_nxt  = STABLE0;
               w_cnt_nxt    = '0;
               w_glitch_nxt = w_glitch_inc;
            end else if (r_cnt == c_cnt_last) begin
               w_state_nxt = STABLE1;
               w_cnt_nxt   = '0;
               w_q_nxt     = 1'b1;
               w_rise_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         STABLE1: begin
            if (!w_s) begin
               w_state_nxt = PEND0;
               w_cnt_nxt   = c_cnt_one;
            end
         end
         PEND0: begin
            if (w_s) begin
               w_state_nxt  = STABLE1;
               w_cnt_nxt    = '0;
               w_glitch_nxt = w_glitch_inc;
            end else if (r_cnt == c_cnt_last) begin
               w_state_nxt = STABLE0;
               w_cnt_nxt   = '0;
               w_q_nxt     = 1'b0;
               w_fall_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = STABLE0;
            w_cnt_nxt   = '0;
            w_q_nxt     = 1'b0;
         end
      endcase
   end

   assign bus.q          = r_q;
   assign bus.rise       = r_rise;
   assign bus.fall       = r_fall;
   assign bus.glitch_cnt = r_glitch;

endmodule : debounce_sync
`default_nettype wire

// File: tb/tb_debounce_sync.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debounce_sync
//  Description : Directed self-checking bench for debounce_sync with
//                STABLE_CYCLES=4, GLITCH_W=8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_sync;

   localparam int c_stable = 4;
   localparam int c_gw     = 8;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;
   int   rise_seen;

   debounce_sync_if #(.GLITCH_W(c_gw)) bus ();

   debounce_sync #(
      .STABLE_CYCLES (c_stable),
      .CNT_W         (8),
      .GLITCH_W      (c_gw)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      rise_seen = 0;
      reset     = 1'b1;
      bus.d     = 1'b1;

`ifdef DEBOUNCE_SYNC_EN
      // Synchronizer build: two extra edges before the filter sees d
      repeat (2) step();
      reset = 1'b0;
      for (int e = 0; e <= 4; e++) begin
         step();
         chk($sformatf("sync_q_E%0d", e), 32'(bus.q), 32'd0);
         chk($sformatf("sync_rise_E%0d", e), 32'(bus.rise), 32'd0);
      end
      step();
      chk("sync_q_E5", 32'(bus.q), 32'd1);
      chk("sync_rise_E5", 32'(bus.rise), 32'd1);
`else
      // 1: reset held 3 cycles with d=1
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("rst_q_%0d", i), 32'(bus.q), 32'd0);
         chk($sformatf("rst_rise_%0d", i), 32'(bus.rise), 32'd0);
         chk($sformatf("rst_fall_%0d", i), 32'(bus.fall), 32'd0);
         chk($sformatf("rst_glitch_%0d", i), 32'(bus.glitch_cnt), 32'd0);
      end
      reset = 1'b0;

      // 2: d=1 held, commit after E3, pulse gone after E4
      for (int e = 0; e < 3; e++) begin
         step();
         chk($sformatf("rise_q_E%0d", e), 32'(bus.q), 32'd0);
         chk($sformatf("rise_pulse_E%0d", e), 32'(bus.rise), 32'd0);
      end
      step();
      chk("rise_q_E3", 32'(bus.q), 32'd1);
      chk("rise_pulse_E3", 32'(bus.rise), 32'd1);
      chk("rise_fall_E3", 32'(bus.fall), 32'd0);
      step();
      chk("rise_q_E4", 32'(bus.q), 32'd1);
      chk("rise_pulse_E4", 32'(bus.rise), 32'd0);

      // 3: d=0 held, fall after 4th sampling edge
      bus.d = 1'b0;
      for (int e = 0; e < 3; e++) begin
         step();
         chk($sformatf("fall_q_E%0d", e), 32'(bus.q), 32'd1);
         chk($sformatf("fall_pulse_E%0d", e), 32'(bus.fall), 32'd0);
         chk($sformatf("fall_rise_E%0d", e), 32'(bus.rise), 32'd0);
      end
      step();
      chk("fall_q_E3", 32'(bus.q), 32'd0);
      chk("fall_pulse_E3", 32'(bus.fall), 32'd1);
      chk("fall_rise_E3", 32'(bus.rise), 32'd0);
      step();
      chk("fall_pulse_E4", 32'(bus.fall), 32'd0);
      chk("fall_glitch", 32'(bus.glitch_cnt), 32'd0);

      // 4: 3-edge pulses never commit; each aborts and bumps glitch_cnt
      for (int r = 0; r < 300; r++) begin
         bus.d = 1'b1;
         repeat (3) begin
            step();
            if (bus.rise !== 1'b0 || bus.q !== 1'b0) rise_seen++;
         end
         bus.d = 1'b0;
         step();
         if (bus.rise !== 1'b0 || bus.q !== 1'b0) rise_seen++;
         if (r == 0) chk("glitch_first", 32'(bus.glitch_cnt), 32'd1);
         if (r == 254) chk("glitch_254", 32'(bus.glitch_cnt), 32'd255);
      end
      chk("glitch_no_rise", 32'(rise_seen), 32'd0);
      chk("glitch_sat", 32'(bus.glitch_cnt), 32'd255);
      chk("glitch_q", 32'(bus.q), 32'd0);

      // 5: reset during a pending rise discards it
      reset = 1'b1;
      step();
      chk("rst2_glitch", 32'(bus.glitch_cnt), 32'd0);
      reset = 1'b0;
      bus.d = 1'b1;
      repeat (2) step();
      reset = 1'b1;
      step();
      chk("pend_rst_glitch", 32'(bus.glitch_cnt), 32'd0);
      chk("pend_rst_q", 32'(bus.q), 32'd0);
      reset = 1'b0;
      for (int e = 0; e < 3; e++) begin
         step();
         chk($sformatf("post_rst_q_E%0d", e), 32'(bus.q), 32'd0);
      end
      step();
      chk("post_rst_q_E3", 32'(bus.q), 32'd1);
      chk("post_rst_rise_E3", 32'(bus.rise), 32'd1);
      chk("post_rst_glitch", 32'(bus.glitch_cnt), 32'd0);

      // Alternating d: q never moves, glitch counts every second edge
      bus.d = 1'b0;
      step();
      for (int e = 0; e < 8; e++) begin
         bus.d = e[0];
         step();
      end
      chk("toggle_q", 32'(bus.q), 32'd1);
      chk("toggle_glitch", 32'(bus.glitch_cnt), 32'd4);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule : tb_debounce_sync
`default_nettype wire
